// File: rtl/noc_pkg.sv
// Shared constants and helpers for the NoC datapath staging blocks.
// Latency: none (package only).
// Backpressure: not applicable.
package noc_pkg;

    // Default per-bit value of stage data registers on reset (all zeros).
    localparam logic RESET_BIT = 1'b0;

    // Ceiling log2, used to size counters that must hold the value n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: valid flop plus load-enabled data flop.
// Latency: 1 clock from src to v_out/d_out when the stage advances.
// Backpressure: rdy_out = ~v_out | nxt_ready, so an empty slot always accepts.
module pipe_stage
    import noc_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{RESET_BIT}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             nxt_ready,
    output logic             rdy_out,
    output logic             v_out,
    output logic [WIDTH-1:0] d_out
);

    // A slot can take new content if it is empty or its content moves on.
    assign rdy_out = ~v_out | nxt_ready;

    // Valid bit: flush wins over any advance; otherwise follow the source when moving.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_out <= 1'b0;
        end else if (flush) begin
            v_out <= 1'b0;
        end else if (rdy_out) begin
            v_out <= src_valid;
        end
    end

    // Data only loads real items; bubbles leave the register untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= RESET_VAL;
        end else if (!flush && rdy_out && src_valid) begin
            d_out <= src_data;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register pipeline of DEPTH handshaked stages with bubble collapse and flush.
// Latency: DEPTH clocks from input presentation to out_data on an empty, unstalled pipe.
// Backpressure: ready ripples combinationally from out_ready; any empty stage lets input in.
module pipe_reg_chain
    import noc_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{RESET_BIT}},
    localparam int              OCC_W     = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [OCC_W-1:0] occ;

    assign rdy[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;

        if (i == 0) begin : g_head
            assign src_v = in_valid;
            assign src_d = in_data;
        end else begin : g_body
            assign src_v = v[i-1];
            assign src_d = d[i-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .src_valid (src_v),
            .src_data  (src_d),
            .nxt_ready (rdy[i+1]),
            .rdy_out   (rdy[i]),
            .v_out     (v[i]),
            .d_out     (d[i])
        );
    end

    // Flush blocks acceptance so the flushed cycle never swallows an input.
    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // Occupancy is a plain popcount of the stage valid bits.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(v[i]);
        end
    end

    assign occupancy = occ;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain with a DEPTH=2 and a DEPTH=4 instance.
// Inputs change 1 time unit after the rising edge; checks happen before the next edge.
// Expected values are hand-derived constants.
module tb_pipe_reg_chain;

    logic       clk;
    logic       reset;

    logic       flush2, iv2, ir2, ov2, or2;
    logic [7:0] id2, od2;
    logic [1:0] occ2;

    logic       flush4, iv4, ir4, ov4, or4;
    logic [7:0] id4, od4;
    logic [2:0] occ4;

    int total;
    int bad;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush2),
        .in_valid  (iv2),
        .in_data   (id2),
        .in_ready  (ir2),
        .out_valid (ov2),
        .out_data  (od2),
        .out_ready (or2),
        .occupancy (occ2)
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush4),
        .in_valid  (iv4),
        .in_data   (id4),
        .in_ready  (ir4),
        .out_valid (ov4),
        .out_data  (od4),
        .out_ready (or4),
        .occupancy (occ4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        flush2 = 1'b0; iv2 = 1'b0; id2 = 8'h00; or2 = 1'b0;
        flush4 = 1'b0; iv4 = 1'b0; id4 = 8'h00; or4 = 1'b0;

        // Reset held: input activity must not leak into the pipe.
        iv2 = 1'b1; id2 = 8'hA5; or2 = 1'b1;
        iv4 = 1'b1; id4 = 8'hA5;
        tick();
        id2 = 8'h5A;
        tick();
        id2 = 8'hA5;
        tick();
        chk("rst_ov2",  8'(ov2),  8'd0);
        chk("rst_od2",  od2,      8'h00);
        chk("rst_occ2", 8'(occ2), 8'd0);
        chk("rst_ov4",  8'(ov4),  8'd0);
        chk("rst_occ4", 8'(occ4), 8'd0);
        iv2 = 1'b0; iv4 = 1'b0;
        reset = 1'b1;
        #1;
        chk("rel_ir2", 8'(ir2), 8'd1);

        // Streaming through DEPTH=2: item k shows up after the second edge.
        or2 = 1'b1;
        iv2 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            id2 = 8'(k);
            #1;
            chk("str_ir", 8'(ir2), 8'd1);
            tick();
            if (k >= 2) begin
                chk("str_ov", 8'(ov2), 8'd1);
                chk("str_od", od2, 8'(k - 1));
            end
        end
        iv2 = 1'b0;
        tick();
        chk("str_last", od2, 8'd6);
        chk("str_occ1", 8'(occ2), 8'd1);
        tick();
        chk("str_empty", 8'(ov2), 8'd0);
        chk("str_occ0", 8'(occ2), 8'd0);

        // Backpressure fill then drain with same-cycle refill.
        or2 = 1'b0;
        iv2 = 1'b1; id2 = 8'h11;
        tick();
        id2 = 8'h22;
        #1;
        chk("bp_ir_half", 8'(ir2), 8'd1);
        tick();
        id2 = 8'h33;
        #1;
        chk("bp_occ", 8'(occ2), 8'd2);
        chk("bp_ir_full", 8'(ir2), 8'd0);
        chk("bp_od", od2, 8'h11);
        tick();
        chk("bp_hold_od", od2, 8'h11);
        chk("bp_hold_occ", 8'(occ2), 8'd2);
        or2 = 1'b1;
        #1;
        chk("bp_passthru_ir", 8'(ir2), 8'd1);
        tick();
        iv2 = 1'b0;
        chk("bp_out2", od2, 8'h22);
        chk("bp_occ_same", 8'(occ2), 8'd2);
        tick();
        chk("bp_out3", od2, 8'h33);
        tick();
        chk("bp_drained", 8'(ov2), 8'd0);

        // Bubble collapse on DEPTH=4: alternating valids fill all stages.
        or4 = 1'b0;
        for (int s = 0; s < 8; s++) begin
            iv4 = (s % 2 == 0);
            id4 = 8'(8'h40 + s);
            tick();
        end
        iv4 = 1'b1; id4 = 8'h99;
        #1;
        chk("bub_occ", 8'(occ4), 8'd4);
        chk("bub_ir", 8'(ir4), 8'd0);
        iv4 = 1'b0;
        or4 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("bub_ov", 8'(ov4), 8'd1);
            chk("bub_od", od4, 8'(8'h40 + 2 * j));
            tick();
        end
        chk("bub_empty", 8'(ov4), 8'd0);

        // Flush with three items held and a live input that must be refused.
        or4 = 1'b0;
        iv4 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            id4 = 8'(8'h61 + j);
            tick();
        end
        chk("fl_occ3", 8'(occ4), 8'd3);
        id4 = 8'h7E;
        flush4 = 1'b1;
        #1;
        chk("fl_ir", 8'(ir4), 8'd0);
        tick();
        flush4 = 1'b0;
        iv4 = 1'b0;
        chk("fl_occ0", 8'(occ4), 8'd0);
        chk("fl_ov0", 8'(ov4), 8'd0);
        or4 = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("fl_no7e", 8'(ov4), 8'd0);
        end
        iv4 = 1'b1; id4 = 8'h55;
        tick();
        iv4 = 1'b0;
        tick();
        tick();
        chk("lat4_early", 8'(ov4), 8'd0);
        tick();
        chk("lat4_ov", 8'(ov4), 8'd1);
        chk("lat4_od", od4, 8'h55);

        // Asynchronous reset between edges with two items held.
        or2 = 1'b0;
        iv2 = 1'b1; id2 = 8'h81;
        tick();
        id2 = 8'h82;
        tick();
        iv2 = 1'b0;
        chk("ar_occ2", 8'(occ2), 8'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_ov", 8'(ov2), 8'd0);
        chk("ar_occ", 8'(occ2), 8'd0);
        chk("ar_od", od2, 8'h00);
        reset = 1'b1;
        or2 = 1'b1;
        iv2 = 1'b1; id2 = 8'h9C;
        tick();
        iv2 = 1'b0;
        tick();
        chk("ar_new_ov", 8'(ov2), 8'd1);
        chk("ar_new_od", od2, 8'h9C);
        tick();
        chk("ar_new_empty", 8'(ov2), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
